// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD timer constants, state encoding and digit check
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] v);
    return v <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// rtl/bcd_digit_down.sv - one BCD digit with parallel load and borrow chain
module bcd_digit_down
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow_out
);

  // A digit at zero passes the borrow on and wraps to nine.
  assign borrow_out = borrow_in && (q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= ld_val;
    end else if (borrow_in) begin
      q <= (q == '0) ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - BCD countdown timer; BCD_DOWN_TIMER_AUTORELOAD_EN enables auto-reload
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  start,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   q,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int W = DIGIT_W * DIGITS;

  state_t         state, state_nx;
  logic           d_valid;
  logic           q_zero, q_one;
  logic           dig_load, dig_dec, err_nx;
  logic [W-1:0]   load_val;
  logic [DIGITS:0] borrow;

`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
  logic [W-1:0] reload;

  always_ff @(posedge clk) begin
    if (reset) begin
      reload <= '0;
    end else if (load && d_valid) begin
      reload <= d;
    end
  end
`endif

  assign q_zero = (q == '0);
  assign q_one  = (q == W'(1));

  always_comb begin
    d_valid  = 1'b1;
    state_nx = state;
    dig_load = 1'b0;
    dig_dec  = 1'b0;
    load_val = d;
    err_nx   = 1'b0;

    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_ok(d[DIGIT_W*i +: DIGIT_W])) d_valid = 1'b0;
    end

    // Any load request, even a rejected one, blocks start and counting.
    case (state)
      ST_IDLE: begin
        if (!load && start && !q_zero) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (!load && en && !q_zero) begin
          dig_dec = 1'b1;
          if (q_one) state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        dig_load = 1'b1;
        load_val = '0;
        state_nx = ST_IDLE;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
        if (reload != '0) begin
          load_val = reload;
          state_nx = ST_RUN;
        end
`endif
      end
      default: state_nx = ST_IDLE;
    endcase

    if (load) begin
      if (d_valid) begin
        dig_load = 1'b1;
        load_val = d;
        dig_dec  = 1'b0;
        state_nx = ST_IDLE;
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  assign borrow[0] = dig_dec;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_down u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (dig_load),
      .ld_val     (load_val[DIGIT_W*g +: DIGIT_W]),
      .borrow_in  (borrow[g]),
      .q          (q[DIGIT_W*g +: DIGIT_W]),
      .borrow_out (borrow[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != ST_IDLE);
      done  <= (state_nx == ST_DONE);
      err   <= err_nx;
    end
  end

endmodule
